bicubic_wb_collector: RTL and testbench



---
 rtl/bicubic_wb_collector_pkg.sv | 17 +
 rtl/bicubic_wb_line_ram.sv | 24 ++
 rtl/bicubic_wb_collector.sv | 193 +++++++++++++++++++
 tb/tb_bicubic_wb_collector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_wb_collector_pkg.sv
// rtl/bicubic_wb_collector_pkg.sv - shared constants, state encoding and counter widths
package bicubic_wb_collector_pkg;

  localparam int DEF_BUFFER_WIDTH = 24;
  localparam int SCALE            = 4;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bicubic_wb_line_ram.sv
// rtl/bicubic_wb_line_ram.sv - simple dual-port line memory, one write port, registered read
module bicubic_wb_line_ram #(
  parameter int DEPTH = 960,
  parameter int WIDTH = 96,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read data holds its value while rd_en is low; the drain relies on this.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bicubic_wb_collector.sv
// rtl/bicubic_wb_collector.sv - stages 4 output lines per input row and drains them as a pixel stream
// Optional simulation trace: BICUBIC_WB_TRACE_EN
module bicubic_wb_collector
  import bicubic_wb_collector_pkg::*;
#(
  parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
  parameter int IN_WIDTH     = 960,
  parameter int IN_HEIGHT    = 540
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bcci_rsp_valid,
  output logic                    bf_rsp_ready,
  input  logic [BUFFER_WIDTH-1:0] bcci_rsp_data1,
  input  logic [BUFFER_WIDTH-1:0] bcci_rsp_data2,
  input  logic [BUFFER_WIDTH-1:0] bcci_rsp_data3,
  input  logic [BUFFER_WIDTH-1:0] bcci_rsp_data4,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BUFFER_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    out_sof
);

  localparam int CW = cnt_w(IN_WIDTH);
  localparam int RW = cnt_w(IN_HEIGHT);
  localparam int WW = SCALE * BUFFER_WIDTH;
  localparam logic [CW-1:0] COL_MAX = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IN_HEIGHT - 1);

  wb_state_e state_q, state_d;

  logic [1:0]    k;
  logic [CW-1:0] col;
  logic          wr_en_q;
  logic [1:0]    wr_bank_q;
  logic [CW-1:0] wr_addr_q;
  logic [WW-1:0] wr_data_q;

  logic [1:0]    rd_bank;
  logic [CW-1:0] rd_word;
  logic          rd_done;
  logic [1:0]    rd_sel;
  logic          pf_valid, pf_last, pf_first, pf_final;
  logic [WW-1:0] sh_word;
  logic [1:0]    pix;
  logic          sh_last, sh_final;
  logic [RW-1:0] in_row;

  logic [WW-1:0] bank_rdata [SCALE];
  logic [WW-1:0] pf_data;
  logic rsp_fire, fill_done, out_fire, word_end, drain_done, load, rd_en;

  assign rsp_fire   = bcci_rsp_valid && (state_q == FILL);
  assign fill_done  = rsp_fire && (k == 2'd3) && (col == COL_MAX);
  assign out_fire   = out_valid && out_ready;
  assign word_end   = out_fire && (pix == 2'd3);
  assign drain_done = word_end && sh_final;
  assign pf_data    = bank_rdata[rd_sel];
  // The serializer takes the prefetched word when idle or as it retires its last pixel.
  assign load       = pf_valid && (!out_valid || word_end);
  assign rd_en      = (state_q == DRAIN) && !rd_done && (!pf_valid || load);
  assign out_data   = sh_word[BUFFER_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bf_rsp_ready = 1'b0;
    case (state_q)
      FILL: begin
        bf_rsp_ready = 1'b1;
        if (fill_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Fill side: write is registered, landing one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      col       <= '0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= rsp_fire;
      if (rsp_fire) begin
        wr_bank_q <= k;
        wr_addr_q <= col;
        wr_data_q <= {bcci_rsp_data4, bcci_rsp_data3, bcci_rsp_data2, bcci_rsp_data1};
        k         <= k + 1'b1;
        if (k == 2'd3) col <= (col == COL_MAX) ? '0 : col + 1'b1;
      end
    end
  end

  // Drain side: read issue, prefetch tags and pixel serializer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank   <= '0;
      rd_word   <= '0;
      rd_done   <= 1'b0;
      rd_sel    <= '0;
      pf_valid  <= 1'b0;
      pf_last   <= 1'b0;
      pf_first  <= 1'b0;
      pf_final  <= 1'b0;
      sh_word   <= '0;
      pix       <= '0;
      sh_last   <= 1'b0;
      sh_final  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sof   <= 1'b0;
      in_row    <= '0;
    end else begin
      pf_valid <= rd_en || (pf_valid && !load);
      if (rd_en) begin
        rd_sel   <= rd_bank;
        pf_last  <= (rd_word == COL_MAX);
        pf_first <= (rd_word == '0) && (rd_bank == 2'd0) && (in_row == '0);
        pf_final <= (rd_word == COL_MAX) && (rd_bank == 2'd3);
        if (rd_word == COL_MAX) begin
          rd_word <= '0;
          rd_bank <= rd_bank + 1'b1;
          if (rd_bank == 2'd3) rd_done <= 1'b1;
        end else begin
          rd_word <= rd_word + 1'b1;
        end
      end

      if (load) begin
        sh_word   <= pf_data;
        pix       <= '0;
        sh_last   <= pf_last;
        sh_final  <= pf_final;
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        out_sof   <= pf_first;
      end else if (word_end) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_sof   <= 1'b0;
      end else if (out_fire) begin
        sh_word  <= sh_word >> BUFFER_WIDTH;
        pix      <= pix + 1'b1;
        out_sof  <= 1'b0;
        out_last <= sh_last && (pix == 2'd2);
      end

      if (drain_done) begin
        rd_done <= 1'b0;
        in_row  <= (in_row == ROW_MAX) ? '0 : in_row + 1'b1;
      end
    end
  end

  genvar b;
  for (b = 0; b < SCALE; b++) begin : g_bank
    bicubic_wb_line_ram #(
      .DEPTH(IN_WIDTH),
      .WIDTH(WW),
      .AW   (CW)
    ) u_ram (
      .clk    (clk),
      .wr_en  (wr_en_q && (wr_bank_q == 2'(b))),
      .wr_addr(wr_addr_q),
      .wr_data(wr_data_q),
      .rd_en  (rd_en && (rd_bank == 2'(b))),
      .rd_addr(rd_word),
      .rd_data(bank_rdata[b])
    );
  end

`ifdef BICUBIC_WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && out_fire) begin
      $display("%h", out_data);
      if (out_last && sh_final && (in_row == ROW_MAX)) $display("frame done");
    end
  end
`endif

endmodule

// File: tb/tb_bicubic_wb_collector.sv
// tb/tb_bicubic_wb_collector.sv - directed table-driven bench for bicubic_wb_collector
module tb_bicubic_wb_collector;

  localparam int BW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bcci_rsp_valid = 1'b0;
  logic bf_rsp_ready;
  logic [BW-1:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic out_last, out_sof;

  always #5 clk = ~clk;

  bicubic_wb_collector #(.BUFFER_WIDTH(BW), .IN_WIDTH(4), .IN_HEIGHT(2)) dut (
    .clk(clk), .rst(rst),
    .bcci_rsp_valid(bcci_rsp_valid), .bf_rsp_ready(bf_rsp_ready),
    .bcci_rsp_data1(d1), .bcci_rsp_data2(d2), .bcci_rsp_data3(d3), .bcci_rsp_data4(d4),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sof(out_sof)
  );

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic          sof;
  } pix_t;

  typedef struct {
    int   row;
    int   bank;
    int   col;
    int   i;
    pix_t exp;
  } vec_t;

  vec_t tbl [128];
  pix_t cap [$];
  int   total = 0;
  int   bad = 0;
  int   rsp_acc = 0;
  pix_t prev;
  bit   prev_stall = 1'b0;

  function automatic logic [BW-1:0] tag(int row, int k, int col, int i);
    return {8'(row), 4'(k), 4'(col), 4'h0, 4'(i)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: captures accepted pixels, counts accepted responses, checks stall stability.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          if (!(out_valid && out_data == prev.data && out_last == prev.last && out_sof == prev.sof)) begin
            bad++;
            $display("FAIL stall_hold actual=%0b/%h/%0b/%0b required=1/%h/%0b/%0b",
                     out_valid, out_data, out_last, out_sof, prev.data, prev.last, prev.sof);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev = '{data: out_data, last: out_last, sof: out_sof};
        if (out_valid && out_ready) cap.push_back('{data: out_data, last: out_last, sof: out_sof});
        if (bcci_rsp_valid && bf_rsp_ready) rsp_acc++;
      end
    end
  end

  task automatic send_row(int row, bit gaps);
    for (int col = 0; col < 4; col++) begin
      for (int k = 0; k < 4; k++) begin
        bit acc = 1'b0;
        if (gaps) begin
          bcci_rsp_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        bcci_rsp_valid = 1'b1;
        d1 = tag(row, k, col, 0);
        d2 = tag(row, k, col, 1);
        d3 = tag(row, k, col, 2);
        d4 = tag(row, k, col, 3);
        for (int n = 0; n < 500 && !acc; n++) begin
          @(negedge clk);
          acc = bf_rsp_ready;
          @(posedge clk); #1;
        end
        if (!acc) check("rsp_accept_timeout", 32'd0, 32'd1);
      end
    end
    bcci_rsp_valid = 1'b0;
  endtask

  task automatic drain_collect(int target, bit toggle);
    bit done = 1'b0;
    bit ready_hi = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(posedge clk); #1;
      if (cap.size() >= target) done = 1'b1;
      else begin
        if (bf_rsp_ready) ready_hi = 1'b1;
        if (toggle) out_ready = !out_ready;
      end
    end
    out_ready = 1'b1;
    check("drain_timeout", 32'(done), 32'd1);
    check("ready_low_in_drain", 32'(ready_hi), 32'd0);
  endtask

  task automatic compare_run(string name, int base, int tbl_base, int n);
    for (int p = 0; p < n; p++) begin
      vec_t v;
      pix_t a;
      v = tbl[tbl_base + p];
      a = (base + p < cap.size()) ? cap[base + p] : '0;
      total++;
      if (a !== v.exp) begin
        bad++;
        $display("FAIL %s pix=%0d (row%0d bank%0d col%0d i%0d) actual=%h/%0b/%0b required=%h/%0b/%0b",
                 name, p, v.row, v.bank, v.col, v.i, a.data, a.last, a.sof,
                 v.exp.data, v.exp.last, v.exp.sof);
      end
    end
  endtask

  initial begin
    int acc0, base, nsof;

    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 64; p++) begin
        tbl[r*64+p].row  = r;
        tbl[r*64+p].bank = p / 16;
        tbl[r*64+p].col  = (p % 16) / 4;
        tbl[r*64+p].i    = p % 4;
        tbl[r*64+p].exp  = '{data: tag(r, p / 16, (p % 16) / 4, p % 4),
                             last: (p % 16) == 15,
                             sof:  (r == 0) && (p == 0)};
      end
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_ready", 32'(bf_rsp_ready), 32'd1);

    // Row 0, back-to-back, with drain latency checks.
    send_row(0, 1'b0);
    check("lat_e0_ready", 32'(bf_rsp_ready), 32'd0);
    check("lat_e0_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e2_valid", 32'(out_valid), 32'd1);
    check("lat_e2_data", 32'(out_data), 32'(tag(0, 0, 0, 0)));
    drain_collect(64, 1'b0);
    compare_run("row0", 0, 0, 64);

    // Row 1 with out_ready toggling every cycle.
    send_row(1, 1'b0);
    drain_collect(128, 1'b1);
    compare_run("row1_toggle", 64, 64, 64);

    // Second frame: gapped fill, then next row's first response held through the drain.
    send_row(0, 1'b1);
    acc0 = rsp_acc;
    fork
      send_row(1, 1'b0);
      begin
        drain_collect(192, 1'b0);
        check("held_not_taken_in_drain", 32'(rsp_acc), 32'(acc0));
        @(posedge clk); #1;
        check("held_taken_first_fill", 32'(rsp_acc), 32'(acc0 + 1));
      end
    join
    drain_collect(256, 1'b0);
    compare_run("frame2", 128, 0, 128);
    nsof = 0;
    for (int p = 0; p < 256 && p < cap.size(); p++) nsof += cap[p].sof;
    check("sof_count", 32'(nsof), 32'd2);

    // Reset mid-drain after 20 pixels, then a fresh row.
    send_row(1 - 1, 1'b0);
    drain_collect(256 + 20, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(bf_rsp_ready), 32'd1);
    check("midrst_data", 32'(out_data), 32'd0);
    base = cap.size();
    send_row(0, 1'b0);
    drain_collect(base + 64, 1'b0);
    compare_run("after_reset", base, 0, 64);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
